// File: rtl/ram_pkg.sv
// Shared types for the single-port RAM: controller states and read-during-write modes.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RDW_OLD     = 0;
  localparam int RDW_THROUGH = 1;

endpackage

// File: rtl/ram_be_merge.sv
// Byte-enable merge: bytes with be set come from the new word, others keep the old word.
module ram_be_merge #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   i_old,
  input  logic [DATA_W-1:0]   i_new,
  input  logic [DATA_W/8-1:0] i_be,
  output logic [DATA_W-1:0]   o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int unsigned i = 0; i < DATA_W / 8; i++) begin
      if (i_be[i]) o_merged[8*i +: 8] = i_new[8*i +: 8];
    end
  end

endmodule

// File: rtl/ram_sp_param.sv
// Single-port RAM with byte enables, power-on clear sequencer, 1-cycle registered read
// and selectable read-during-write behaviour.
module ram_sp_param
  import ram_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 5,
  parameter int              RDW_MODE  = RDW_OLD,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter logic [DATA_W-1:0] IDLE_VAL  = '1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                chip_s,
  input  logic                w_en,
  input  logic                r_en,
  input  logic                o_en,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                busy
);

  localparam int              DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_rd;
  logic              r_rd_valid;

  logic              w_ready;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rd_next;

  assign w_ready  = (r_state == READY);
  assign w_wr_acc = w_ready & chip_s & w_en;
  assign w_rd_acc = w_ready & chip_s & r_en;
  assign w_old    = r_mem[address];

  // One merge feeds both the memory write and the write-through read path
  ram_be_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .i_old    (w_old),
    .i_new    (data_in),
    .i_be     (be),
    .o_merged (w_merged)
  );

  assign w_rd_next = ((RDW_MODE == RDW_THROUGH) && w_wr_acc) ? w_merged : w_old;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_ptr      <= '0;
      r_rd       <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        CLEAR: begin
          if (r_ptr == LAST) r_state <= READY;
          else               r_ptr   <= r_ptr + ADDR_W'(1);
        end
        READY: begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd <= w_rd_next;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Memory array carries no reset; the clear sequence is its only initialisation
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) r_mem[r_ptr]   <= CLEAR_VAL;
      else if (w_wr_acc)    r_mem[address] <= w_merged;
    end
  end

  assign rd_valid = r_rd_valid;
  assign busy     = rst | (r_state == CLEAR);
  assign data_out = (chip_s & o_en) ? r_rd : IDLE_VAL;

endmodule

// File: tb/tb_ram_sp_param.sv
// Scoreboard bench: an 8-bit read-old RAM and a 32-bit write-through RAM share stimulus.
module tb_ram_sp_param;

  localparam int          DEPTH  = 32;
  localparam logic [31:0] CV_B   = 32'h5A5A_A5A5;
  localparam logic [31:0] IDLE_B = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, chip_s = 1'b0, w_en = 1'b0, r_en = 1'b0, o_en = 1'b0;
  logic [4:0]  address = '0;
  logic [7:0]  din_a = '0;
  logic [0:0]  be_a = 1'b1;
  logic [31:0] din_b = '0;
  logic [3:0]  be_b = '1;
  logic [7:0]  dout_a;
  logic [31:0] dout_b;
  logic        rdv_a, rdv_b, busy_a, busy_b;

  ram_sp_param u_dut_a (
    .clk(clk), .rst(rst), .chip_s(chip_s), .w_en(w_en), .r_en(r_en), .o_en(o_en),
    .be(be_a), .address(address), .data_in(din_a),
    .data_out(dout_a), .rd_valid(rdv_a), .busy(busy_a)
  );

  ram_sp_param #(
    .DATA_W(32), .ADDR_W(5), .RDW_MODE(1), .CLEAR_VAL(CV_B), .IDLE_VAL(IDLE_B)
  ) u_dut_b (
    .clk(clk), .rst(rst), .chip_s(chip_s), .w_en(w_en), .r_en(r_en), .o_en(o_en),
    .be(be_b), .address(address), .data_in(din_b),
    .data_out(dout_b), .rd_valid(rdv_b), .busy(busy_b)
  );

  logic [7:0]  m_a [DEPTH];
  logic [31:0] m_b [DEPTH];
  int          clear_left = DEPTH;
  logic [7:0]  rr_a = '0;
  logic [31:0] rr_b = '0;
  logic [7:0]  q_a [$];
  logic [31:0] q_b [$];
  int          n_chk = 0, n_pass = 0;
  bit          mon_on = 1'b0;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model advances on each rising edge using the inputs held across it
  task automatic step();
    logic [31:0] t;
    @(posedge clk);
    if (rst) begin
      clear_left = DEPTH;
      rr_a = '0;
      rr_b = '0;
    end else if (clear_left > 0) begin
      m_a[DEPTH-clear_left] = 8'h00;
      m_b[DEPTH-clear_left] = CV_B;
      clear_left--;
    end else begin
      if (chip_s && r_en) begin
        q_a.push_back(m_a[address]);
        q_b.push_back(w_en ? merge(m_b[address], din_b, be_b) : m_b[address]);
      end
      if (chip_s && w_en) begin
        t = merge({24'h0, m_a[address]}, {24'h0, din_a}, {3'b0, be_a});
        m_a[address] = t[7:0];
        m_b[address] = merge(m_b[address], din_b, be_b);
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("busy_a", {31'b0, busy_a}, {31'b0, rst || clear_left != 0});
      check("busy_b", {31'b0, busy_b}, {31'b0, rst || clear_left != 0});
      check("rd_valid_a", {31'b0, rdv_a}, {31'b0, q_a.size() != 0});
      check("rd_valid_b", {31'b0, rdv_b}, {31'b0, q_b.size() != 0});
      if (q_a.size() != 0) rr_a = q_a.pop_front();
      if (q_b.size() != 0) rr_b = q_b.pop_front();
      check("data_out_a", {24'h0, dout_a}, {24'h0, (chip_s && o_en) ? rr_a : 8'hFF});
      check("data_out_b", dout_b, (chip_s && o_en) ? rr_b : IDLE_B);
    end
  end

  task automatic op(bit w, bit r, bit oe, logic [4:0] a, logic [31:0] d, logic [3:0] b);
    chip_s = 1'b1; w_en = w; r_en = r; o_en = oe; address = a;
    din_b = d; din_a = d[7:0]; be_b = b; be_a = b[0];
    step();
  endtask

  task automatic rand_ops(int n);
    repeat (n) begin
      chip_s  = ($urandom_range(0, 3) != 0);
      w_en    = 1'($urandom_range(0, 1));
      r_en    = 1'($urandom_range(0, 1));
      o_en    = 1'($urandom_range(0, 1));
      address = 5'($urandom_range(0, DEPTH - 1));
      din_b   = $urandom;
      din_a   = 8'($urandom_range(0, 255));
      be_b    = 4'($urandom_range(0, 15));
      be_a    = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  // Requests stay asserted during the clear to show they are dropped
  task automatic release_and_count();
    int cnt;
    cnt = 0;
    chip_s = 1'b1; w_en = 1'b1; r_en = 1'b1; o_en = 1'b1; address = 5'd4;
    din_a = 8'h77; din_b = 32'h7777_7777; be_a = 1'b1; be_b = '1;
    rst = 1'b0;
    while (busy_a && cnt < 100) begin
      step();
      cnt++;
    end
    check("busy_cycles", cnt, 32);
    check("busy_b_done", {31'b0, busy_b}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    mon_on = 1'b1;
    step();
    step();
    release_and_count();

    for (int a = 0; a < DEPTH; a++) op(1'b0, 1'b1, 1'b1, 5'(a), 32'h0, 4'h0);

    op(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_00A5, 4'hF);
    op(1'b0, 1'b1, 1'b1, 5'd3, 32'h0, 4'h0);
    op(1'b0, 1'b0, 1'b1, 5'd3, 32'h0, 4'h0);
    op(1'b0, 1'b0, 1'b0, 5'd3, 32'h0, 4'h0);

    op(1'b1, 1'b0, 1'b1, 5'd7, 32'h1122_3344, 4'hF);
    op(1'b1, 1'b0, 1'b1, 5'd7, 32'hAABB_CCDD, 4'b0101);
    op(1'b0, 1'b1, 1'b1, 5'd7, 32'h0, 4'h0);
    op(1'b0, 1'b0, 1'b1, 5'd7, 32'h0, 4'h0);

    op(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0010, 4'hF);
    op(1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_0020, 4'hF);
    op(1'b0, 1'b1, 1'b1, 5'd5, 32'h0, 4'h0);
    op(1'b0, 1'b0, 1'b1, 5'd5, 32'h0, 4'h0);

    rand_ops(300);

    rst = 1'b1; chip_s = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    release_and_count();

    rand_ops(150);

    chip_s = 1'b0; w_en = 1'b0; r_en = 1'b0;
    step();
    step();
    check("queue_drain", q_a.size() + q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
